// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ALU op encoding, MIPS opcode/funct constants and
// the write-data, branch and jump select encodings used by decode and execute.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    DW_ALU = 2'd0,
    DW_PC8 = 2'd1,
    DW_MEM = 2'd2
  } dw_sel_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2
  } branch_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_J    = 2'd1,
    JMP_JAL  = 2'd2,
    JMP_JR   = 2'd3
  } jump_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [4:0] REG_RA = 5'd31;
  localparam int unsigned JAL_LINK_OFS = 8;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational MIPS decoder: instruction word to control bundle,
// plus the source-usage flags the pipeline needs for its load-use check.
module decode_comb
  import cpu_defs_pkg::*;
#(
  parameter int EXT_OPS = 1,
  parameter int DATA_W  = 32
) (
  input  logic [31:0]       instr,
  output logic [4:0]        aa,
  output logic [4:0]        ab,
  output logic [4:0]        aw,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        alu_op,
  output logic              imm_sel,
  output logic              mem_wr_en,
  output logic              reg_wr_en,
  output logic [1:0]        dw_sel,
  output logic [1:0]        branch,
  output logic [1:0]        jump,
  output logic              illegal,
  output logic              rs_used,
  output logic              rt_used
);

  localparam bit EXT = (EXT_OPS != 0);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic        zext;
  logic        is_jal;
  logic        unused_shamt;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  // The shift amount field has no meaning for any supported instruction.
  assign unused_shamt = ^instr[10:6];

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    aa        = rs;
    ab        = rt;
    aw        = rd;
    alu_op    = ALU_ADD;
    imm_sel   = 1'b0;
    mem_wr_en = 1'b0;
    reg_wr_en = 1'b0;
    dw_sel    = DW_ALU;
    branch    = BR_NONE;
    jump      = JMP_NONE;
    illegal   = 1'b0;
    zext      = 1'b0;
    is_jal    = 1'b0;
    rs_used   = 1'b1;
    rt_used   = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        rt_used   = 1'b1;
        reg_wr_en = 1'b1;
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_SLT: alu_op = ALU_SLT;
          FN_XOR: alu_op = ALU_XOR;
          FN_AND: if (EXT) alu_op = ALU_AND; else illegal = 1'b1;
          FN_OR:  if (EXT) alu_op = ALU_OR;  else illegal = 1'b1;
          FN_NOR: if (EXT) alu_op = ALU_NOR; else illegal = 1'b1;
          FN_JR: begin
            jump      = JMP_JR;
            reg_wr_en = 1'b0;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        aw        = rt;
        imm_sel   = 1'b1;
        reg_wr_en = 1'b1;
        dw_sel    = DW_MEM;
      end
      OP_SW: begin
        imm_sel   = 1'b1;
        mem_wr_en = 1'b1;
        rt_used   = 1'b1;
      end
      OP_ADDI: begin
        aw        = rt;
        imm_sel   = 1'b1;
        reg_wr_en = 1'b1;
      end
      OP_XORI: begin
        aw        = rt;
        imm_sel   = 1'b1;
        reg_wr_en = 1'b1;
        alu_op    = ALU_XOR;
        zext      = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_SLTI: begin
        if (EXT) begin
          aw        = rt;
          imm_sel   = 1'b1;
          reg_wr_en = 1'b1;
          zext      = (opcode != OP_SLTI);
          alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                      (opcode == OP_ORI)  ? ALU_OR  : ALU_SLT;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_BEQ, OP_BNE: begin
        alu_op  = ALU_SUB;
        rt_used = 1'b1;
        branch  = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      OP_J: begin
        jump    = JMP_J;
        rs_used = 1'b0;
      end
      OP_JAL: begin
        jump      = JMP_JAL;
        aw        = REG_RA;
        imm_sel   = 1'b1;
        reg_wr_en = 1'b1;
        dw_sel    = DW_PC8;
        rs_used   = 1'b0;
        is_jal    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // An unrecognised word must never change architectural state.
    if (illegal) begin
      reg_wr_en = 1'b0;
      mem_wr_en = 1'b0;
      branch    = BR_NONE;
      jump      = JMP_NONE;
    end
  end

  always_comb begin
    if (is_jal)    imm = DATA_W'(JAL_LINK_OFS);
    else if (zext) imm = DATA_W'(imm16);
    else           imm = DATA_W'($signed(imm16));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake around decode_comb, with an
// output bundle register, flush, and a load-use interlock that inserts bubbles.
module decode_stage
  import cpu_defs_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int DATA_W   = 32,
  parameter int EXT_OPS  = 1,
  parameter int LU_STALL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [4:0]        out_aa,
  output logic [4:0]        out_ab,
  output logic [4:0]        out_aw,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_alu_op,
  output logic              out_imm_sel,
  output logic              out_mem_wr_en,
  output logic              out_reg_wr_en,
  output logic [1:0]        out_dw_sel,
  output logic [1:0]        out_branch,
  output logic [1:0]        out_jump,
  output logic [PC_W-1:0]   out_jtarget,
  output logic              out_illegal
);

  localparam bit         LU_EN   = (LU_STALL != 0);
  localparam logic [1:0] STALL_LD = 2'(LU_STALL);

  logic [4:0]        d_aa, d_ab, d_aw;
  logic [DATA_W-1:0] d_imm;
  logic [2:0]        d_alu_op;
  logic              d_imm_sel, d_mem_wr_en, d_reg_wr_en;
  logic [1:0]        d_dw_sel, d_branch, d_jump;
  logic              d_illegal, d_rs_used, d_rt_used;
  logic [PC_W-1:0]   jt_next;

  decode_comb #(
    .EXT_OPS (EXT_OPS),
    .DATA_W  (DATA_W)
  ) u_dec (
    .instr     (in_instr),
    .aa        (d_aa),
    .ab        (d_ab),
    .aw        (d_aw),
    .imm       (d_imm),
    .alu_op    (d_alu_op),
    .imm_sel   (d_imm_sel),
    .mem_wr_en (d_mem_wr_en),
    .reg_wr_en (d_reg_wr_en),
    .dw_sel    (d_dw_sel),
    .branch    (d_branch),
    .jump      (d_jump),
    .illegal   (d_illegal),
    .rs_used   (d_rs_used),
    .rt_used   (d_rt_used)
  );

  generate
    if (PC_W > 28) begin : g_jt_hi
      logic [PC_W-29:0] pc_hi;
      assign pc_hi   = (PC_W-28)'((in_pc + PC_W'(4)) >> 28);
      assign jt_next = {pc_hi, in_instr[25:0], 2'b00};
    end else begin : g_jt_lo
      assign jt_next = {in_instr[25:0], 2'b00};
    end
  endgenerate

  logic       out_free;
  logic       hazard;
  logic       stall;
  logic       accept;
  logic [1:0] stall_cnt;
  logic [1:0] cnt_dec;
  logic [1:0] cnt_next;

  assign out_free = !out_valid || out_ready;

  // The held bundle is a load whose destination the incoming word reads.
  assign hazard = LU_EN && out_valid && (out_dw_sel == DW_MEM) &&
                  (out_aw != 5'd0) && in_valid &&
                  ((d_rs_used && (d_aa == out_aw)) ||
                   (d_rt_used && (d_ab == out_aw)));

  // The counter holds bubbles still owed including the current cycle, so the
  // cycle that retires the last one already lets the consumer through.
  assign cnt_dec  = (stall_cnt != 2'd0 && out_free) ? stall_cnt - 2'd1 : stall_cnt;
  assign stall    = hazard || (cnt_dec != 2'd0);
  assign in_ready = flush || (out_free && !stall);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    cnt_next = cnt_dec;
    if (flush)       cnt_next = 2'd0;
    else if (hazard) cnt_next = STALL_LD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      stall_cnt     <= 2'd0;
      out_pc        <= '0;
      out_aa        <= '0;
      out_ab        <= '0;
      out_aw        <= '0;
      out_imm       <= '0;
      out_alu_op    <= '0;
      out_imm_sel   <= 1'b0;
      out_mem_wr_en <= 1'b0;
      out_reg_wr_en <= 1'b0;
      out_dw_sel    <= '0;
      out_branch    <= '0;
      out_jump      <= '0;
      out_jtarget   <= '0;
      out_illegal   <= 1'b0;
    end else begin
      stall_cnt <= cnt_next;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_aa        <= d_aa;
        out_ab        <= d_ab;
        out_aw        <= d_aw;
        out_imm       <= d_imm;
        out_alu_op    <= d_alu_op;
        out_imm_sel   <= d_imm_sel;
        out_mem_wr_en <= d_mem_wr_en;
        out_reg_wr_en <= d_reg_wr_en;
        out_dw_sel    <= d_dw_sel;
        out_branch    <= d_branch;
        out_jump      <= d_jump;
        out_jtarget   <= jt_next;
        out_illegal   <= d_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with extended ops enabled and
// one without, sharing stimulus; expected values are hand-computed constants.
module tb_decode_stage;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_ready;

  logic              a_in_ready, a_out_valid, a_out_imm_sel, a_out_mem_wr_en;
  logic              a_out_reg_wr_en, a_out_illegal;
  logic [PC_W-1:0]   a_out_pc, a_out_jtarget;
  logic [4:0]        a_out_aa, a_out_ab, a_out_aw;
  logic [DATA_W-1:0] a_out_imm;
  logic [2:0]        a_out_alu_op;
  logic [1:0]        a_out_dw_sel, a_out_branch, a_out_jump;

  logic              b_in_ready, b_out_valid, b_out_imm_sel, b_out_mem_wr_en;
  logic              b_out_reg_wr_en, b_out_illegal;
  logic [PC_W-1:0]   b_out_pc, b_out_jtarget;
  logic [4:0]        b_out_aa, b_out_ab, b_out_aw;
  logic [DATA_W-1:0] b_out_imm;
  logic [2:0]        b_out_alu_op;
  logic [1:0]        b_out_dw_sel, b_out_branch, b_out_jump;

  int errors = 0;
  int checks = 0;

  decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .EXT_OPS(1), .LU_STALL(1)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (a_in_ready),
    .in_instr (in_instr), .in_pc (in_pc), .flush (flush),
    .out_valid (a_out_valid), .out_ready (out_ready), .out_pc (a_out_pc),
    .out_aa (a_out_aa), .out_ab (a_out_ab), .out_aw (a_out_aw),
    .out_imm (a_out_imm), .out_alu_op (a_out_alu_op), .out_imm_sel (a_out_imm_sel),
    .out_mem_wr_en (a_out_mem_wr_en), .out_reg_wr_en (a_out_reg_wr_en),
    .out_dw_sel (a_out_dw_sel), .out_branch (a_out_branch), .out_jump (a_out_jump),
    .out_jtarget (a_out_jtarget), .out_illegal (a_out_illegal)
  );

  decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .EXT_OPS(0), .LU_STALL(1)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (b_in_ready),
    .in_instr (in_instr), .in_pc (in_pc), .flush (flush),
    .out_valid (b_out_valid), .out_ready (out_ready), .out_pc (b_out_pc),
    .out_aa (b_out_aa), .out_ab (b_out_ab), .out_aw (b_out_aw),
    .out_imm (b_out_imm), .out_alu_op (b_out_alu_op), .out_imm_sel (b_out_imm_sel),
    .out_mem_wr_en (b_out_mem_wr_en), .out_reg_wr_en (b_out_reg_wr_en),
    .out_dw_sel (b_out_dw_sel), .out_branch (b_out_branch), .out_jump (b_out_jump),
    .out_jtarget (b_out_jtarget), .out_illegal (b_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, confirm it is accepted, and let it transfer.
  task automatic put(input string tag, input logic [31:0] ins, input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    #1;
    check({tag, "_rdy"}, 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    check({tag, "_pc"}, 64'(a_out_pc), 64'(pc));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_ready", 64'(a_in_ready), 64'd1);
    check("rst_aw", 64'(a_out_aw), 64'd0);
    check("rst_imm", 64'(a_out_imm), 64'd0);
    check("rst_pc", 64'(a_out_pc), 64'd0);
    check("rst_jtarget", 64'(a_out_jtarget), 64'd0);
    check("rst_ctrl", 64'({a_out_alu_op, a_out_imm_sel, a_out_mem_wr_en, a_out_reg_wr_en,
                          a_out_dw_sel, a_out_branch, a_out_jump, a_out_illegal}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // addi $8,$0,-1
    put("addi", 32'h2008FFFF, 32'h100);
    check("addi_aw", 64'(a_out_aw), 64'd8);
    check("addi_imm", 64'(a_out_imm), 64'hFFFFFFFF);
    check("addi_alu", 64'(a_out_alu_op), 64'd0);
    check("addi_imm_sel", 64'(a_out_imm_sel), 64'd1);
    check("addi_reg_wr", 64'(a_out_reg_wr_en), 64'd1);
    check("addi_ab", 64'(a_out_ab), 64'd8);

    // ori $9,$8,0xFFFF zero-extends; illegal without extended ops
    put("ori", 32'h3509FFFF, 32'h104);
    check("ori_imm", 64'(a_out_imm), 64'h0000FFFF);
    check("ori_aw", 64'(a_out_aw), 64'd9);
    check("ori_alu", 64'(a_out_alu_op), 64'd7);
    check("ori_b_illegal", 64'(b_out_illegal), 64'd1);
    check("ori_b_reg_wr", 64'(b_out_reg_wr_en), 64'd0);

    // jal 0x40 at 0x00400000
    put("jal", 32'h0C000040, 32'h00400000);
    check("jal_aw", 64'(a_out_aw), 64'd31);
    check("jal_imm", 64'(a_out_imm), 64'd8);
    check("jal_dw_sel", 64'(a_out_dw_sel), 64'd1);
    check("jal_jtarget", 64'(a_out_jtarget), 64'h00000100);
    check("jal_jump", 64'(a_out_jump), 64'd2);
    check("jal_imm_sel", 64'(a_out_imm_sel), 64'd1);

    // Backpressure: jal must hold while add $10,$8,$11 waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h010B5020;
    in_pc     = 32'h00400004;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy", 64'(a_in_ready), 64'd0);
      tick();
      check("bp_valid", 64'(a_out_valid), 64'd1);
      check("bp_pc", 64'(a_out_pc), 64'h00400000);
      check("bp_aw", 64'(a_out_aw), 64'd31);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", 64'(a_out_valid), 64'd1);
    check("bp_next_pc", 64'(a_out_pc), 64'h00400004);
    check("bp_next_aw", 64'(a_out_aw), 64'd10);
    check("bp_next_imm_sel", 64'(a_out_imm_sel), 64'd0);
    tick();
    check("drain_valid", 64'(a_out_valid), 64'd0);

    // beq $8,$9,-4
    put("beq", 32'h1109FFFC, 32'h180);
    check("beq_branch", 64'(a_out_branch), 64'd1);
    check("beq_alu", 64'(a_out_alu_op), 64'd1);
    check("beq_imm", 64'(a_out_imm), 64'hFFFFFFFC);
    check("beq_reg_wr", 64'(a_out_reg_wr_en), 64'd0);

    // Load-use: lw $8,0($9) then add $10,$8,$11 gives exactly one bubble
    put("lu_lw", 32'h8D280000, 32'h200);
    check("lu_lw_dw_sel", 64'(a_out_dw_sel), 64'd2);
    check("lu_lw_aw", 64'(a_out_aw), 64'd8);
    in_valid = 1'b1;
    in_instr = 32'h010B5020;
    in_pc    = 32'h204;
    #1;
    check("lu_stall_rdy", 64'(a_in_ready), 64'd0);
    tick();
    check("lu_bubble_valid", 64'(a_out_valid), 64'd0);
    check("lu_bubble_rdy", 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("lu_add_valid", 64'(a_out_valid), 64'd1);
    check("lu_add_pc", 64'(a_out_pc), 64'h204);

    // Same pair with $0 as the load destination: no bubble
    put("z_lw", 32'h8D200000, 32'h300);
    in_valid = 1'b1;
    in_instr = 32'h000B5020;
    in_pc    = 32'h304;
    #1;
    check("z_rdy", 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("z_add_valid", 64'(a_out_valid), 64'd1);
    check("z_add_pc", 64'(a_out_pc), 64'h304);

    // Flush during the bubble drops the waiting add
    put("fl_lw", 32'h8D280000, 32'h400);
    in_valid = 1'b1;
    in_instr = 32'h010B5020;
    in_pc    = 32'h404;
    #1;
    check("fl_stall_rdy", 64'(a_in_ready), 64'd0);
    tick();
    flush = 1'b1;
    #1;
    check("fl_flush_rdy", 64'(a_in_ready), 64'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_valid", 64'(a_out_valid), 64'd0);
    check("fl_after_rdy", 64'(a_in_ready), 64'd1);

    // Flush in the detection cycle clears the lw and the interlock together
    put("fd_lw", 32'h8D280000, 32'h500);
    in_valid = 1'b1;
    in_instr = 32'h010B5020;
    in_pc    = 32'h504;
    flush    = 1'b1;
    #1;
    check("fd_flush_rdy", 64'(a_in_ready), 64'd1);
    tick();
    flush = 1'b0;
    #1;
    check("fd_valid", 64'(a_out_valid), 64'd0);
    check("fd_rdy", 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("fd_add_valid", 64'(a_out_valid), 64'd1);
    check("fd_add_pc", 64'(a_out_pc), 64'h504);

    // lw $8 then lw $9,0($8) then add $10,$9,$11: the interlock re-arms
    put("ll_lw1", 32'h8D280000, 32'h600);
    in_valid = 1'b1;
    in_instr = 32'h8D090000;
    in_pc    = 32'h604;
    #1;
    check("ll_rdy1", 64'(a_in_ready), 64'd0);
    tick();
    check("ll_bubble1", 64'(a_out_valid), 64'd0);
    tick();
    check("ll_lw2_valid", 64'(a_out_valid), 64'd1);
    check("ll_lw2_aw", 64'(a_out_aw), 64'd9);
    in_instr = 32'h012B5020;
    in_pc    = 32'h608;
    #1;
    check("ll_rdy2", 64'(a_in_ready), 64'd0);
    tick();
    check("ll_bubble2", 64'(a_out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("ll_add_valid", 64'(a_out_valid), 64'd1);
    check("ll_add_pc", 64'(a_out_pc), 64'h608);

    // andi $8,$8,0xF: legal with extended ops, illegal without
    put("andi", 32'h3108000F, 32'h700);
    check("andi_illegal", 64'(a_out_illegal), 64'd0);
    check("andi_alu", 64'(a_out_alu_op), 64'd4);
    check("andi_imm", 64'(a_out_imm), 64'h0000000F);
    check("andi_reg_wr", 64'(a_out_reg_wr_en), 64'd1);
    check("andi_b_valid", 64'(b_out_valid), 64'd1);
    check("andi_b_illegal", 64'(b_out_illegal), 64'd1);
    check("andi_b_reg_wr", 64'(b_out_reg_wr_en), 64'd0);
    check("andi_b_mem_wr", 64'(b_out_mem_wr_en), 64'd0);
    check("andi_b_br_jmp", 64'({b_out_branch, b_out_jump}), 64'd0);

    tick();
    check("end_valid", 64'(a_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
